// File: rtl/exe_mem_skid_if.sv
// EXE->MEM skid buffer bundle interface.
// Groups the upstream handshake and bundle, the downstream handshake and
// bundle, and the registered forwarding tap towards ID.
//   in_*   : EXE bundle and valid/ready handshake (in_ready driven by the stage)
//   out_*  : MEM bundle and valid/ready handshake (out_ready driven by MEM)
//   fwd_*  : forwarding tap and load-pending flag for the hazard unit
// Modports: master = environment (EXE, MEM, ID side), slave = the skid stage.
interface exe_mem_skid_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wreg;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;
    logic [OP_W-1:0]   in_aluop;
    logic [DATA_W-1:0] in_maddr;
    logic              in_is_load;

    logic              out_valid;
    logic              out_ready;
    logic              out_wreg;
    logic [ADDR_W-1:0] out_waddr;
    logic [DATA_W-1:0] out_wdata;
    logic [OP_W-1:0]   out_aluop;
    logic [DATA_W-1:0] out_maddr;
    logic              out_is_load;

    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_waddr;
    logic [DATA_W-1:0] fwd_wdata;
    logic              fwd_load_pending;

    modport master (
        output in_valid, in_wreg, in_waddr, in_wdata, in_aluop, in_maddr, in_is_load,
        output out_ready,
        input  in_ready,
        input  out_valid, out_wreg, out_waddr, out_wdata, out_aluop, out_maddr, out_is_load,
        input  fwd_valid, fwd_waddr, fwd_wdata, fwd_load_pending
    );

    modport slave (
        input  in_valid, in_wreg, in_waddr, in_wdata, in_aluop, in_maddr, in_is_load,
        input  out_ready,
        output in_ready,
        output out_valid, out_wreg, out_waddr, out_wdata, out_aluop, out_maddr, out_is_load,
        output fwd_valid, fwd_waddr, fwd_wdata, fwd_load_pending
    );
endinterface

// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline stage built as a 1- or 2-entry skid FIFO with
// valid/ready handshaking, flush, and a registered forwarding tap to ID.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous reset, active-low
//   flush_i  : drop all held entries and any bundle presented this cycle
//   bus      : exe_mem_skid_if.slave (in_*, out_*, fwd_* signal groups)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | nothing held; out_* is a zero bubble, tap cleared
// ST_ONE   | head entry valid
// ST_TWO   | head and skid entry valid; in_ready low (DEPTH=2 only)
module exe_mem_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    exe_mem_skid_if.slave bus
);

    typedef struct packed {
        logic              wreg;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [OP_W-1:0]   aluop;
        logic [DATA_W-1:0] maddr;
        logic              is_load;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // With a single entry, ready must also open when the head leaves this cycle.
    localparam bit COMB_RDY = (DEPTH == 1);

    state_e            state_q, state_d;
    bundle_t           ent_q [DEPTH];
    bundle_t           ent_d [DEPTH];
    logic              in_ready_q, in_ready_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0] fwd_waddr_q, fwd_waddr_d;
    logic [DATA_W-1:0] fwd_wdata_q, fwd_wdata_d;
    logic              fwd_ld_q, fwd_ld_d;

    logic              head_valid;
    logic              in_ready;
    logic              accept;
    logic              deliver;
    logic [1:0]        cnt;
    bundle_t           in_pl;
    bundle_t           head;
    bundle_t           nxt_head;
    logic              nxt_valid;

    assign head_valid = (state_q != ST_EMPTY);
    // in_ready_q only rises on the first edge after reset, so the
    // combinational term cannot open the stage while reset is held.
    assign in_ready   = in_ready_q | (COMB_RDY & head_valid & bus.out_ready);

    always_comb begin
        in_pl     = {bus.in_wreg, bus.in_waddr, bus.in_wdata,
                     bus.in_aluop, bus.in_maddr, bus.in_is_load};
        accept    = bus.in_valid & in_ready;
        deliver   = head_valid & bus.out_ready;
        ent_d     = ent_q;
        cnt       = state_q;

        // Pop first so a same-cycle push lands at the post-pop tail.
        if (deliver) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i + 1];
            end
            cnt = cnt - 2'd1;
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt == i[1:0]) begin
                    ent_d[i] = in_pl;
                end
            end
            cnt = cnt + 2'd1;
        end

        state_d = state_e'(cnt);
        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (int'(state_d) < DEPTH);

        // The tap is a registered copy of the head that will be presented
        // after this edge, so ID sees exactly what MEM is holding.
        nxt_valid   = (state_d != ST_EMPTY);
        nxt_head    = ent_d[0];
        fwd_valid_d = nxt_valid & nxt_head.wreg & (nxt_head.waddr != '0);
        fwd_waddr_d = nxt_valid ? nxt_head.waddr : '0;
        fwd_wdata_d = nxt_valid ? nxt_head.wdata : '0;
        fwd_ld_d    = fwd_valid_d & nxt_head.is_load;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            fwd_valid_q <= 1'b0;
            fwd_waddr_q <= '0;
            fwd_wdata_q <= '0;
            fwd_ld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            ent_q       <= ent_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_waddr_q <= fwd_waddr_d;
            fwd_wdata_q <= fwd_wdata_d;
            fwd_ld_q    <= fwd_ld_d;
        end
    end

    // Empty stage presents a bubble so MEM never sees a stray write enable.
    assign head = head_valid ? ent_q[0] : '0;

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = head_valid;
    assign bus.out_wreg         = head.wreg;
    assign bus.out_waddr        = head.waddr;
    assign bus.out_wdata        = head.wdata;
    assign bus.out_aluop        = head.aluop;
    assign bus.out_maddr        = head.maddr;
    assign bus.out_is_load      = head.is_load;
    assign bus.fwd_valid        = fwd_valid_q;
    assign bus.fwd_waddr        = fwd_waddr_q;
    assign bus.fwd_wdata        = fwd_wdata_q;
    assign bus.fwd_load_pending = fwd_ld_q;

endmodule
